ppi_cpu_master: RTL

- CPU-side bus initiator for the 8255-style PPI.
- Converts single-cycle internal requests into timed read/write bus cycles: active-low chip select, read and write strobes, the A1:A0 port address, and a bidirectional 8-bit data bus.
- Connects to the PPI's bus_cpu pins, the opposite end of the PPI data bus buffer.
- Used by the system controller and the testbench to program the control word and move port data.

---
 rtl/ppi_cpu_master.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ppi_cpu_master.sv
// CPU-side bus initiator for an 8255-style PPI: turns a one-cycle request into
// a timed chip-select / strobe / data cycle with programmable phase lengths.
module ppi_cpu_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ack,
  output logic       busy,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic [1:0] a,
  inout  wire  [7:0] bus_cpu
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYC - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       we_reg, we_next;
  logic [7:0] wdata_reg, wdata_next;
  logic       drive_reg, drive_next;
  logic       cs_n_reg, cs_n_next;
  logic       rd_n_reg, rd_n_next;
  logic       wr_n_reg, wr_n_next;
  logic [1:0] a_reg, a_next;
  logic [7:0] rdata_reg, rdata_next;
  logic       ack_reg, ack_next;
  logic       busy_reg, busy_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      we_reg    <= 1'b0;
      wdata_reg <= 8'h00;
      drive_reg <= 1'b0;
      cs_n_reg  <= 1'b1;
      rd_n_reg  <= 1'b1;
      wr_n_reg  <= 1'b1;
      a_reg     <= 2'b00;
      rdata_reg <= 8'h00;
      ack_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      we_reg    <= we_next;
      wdata_reg <= wdata_next;
      drive_reg <= drive_next;
      cs_n_reg  <= cs_n_next;
      rd_n_reg  <= rd_n_next;
      wr_n_reg  <= wr_n_next;
      a_reg     <= a_next;
      rdata_reg <= rdata_next;
      ack_reg   <= ack_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req) state_next = SETUP;
      SETUP:   if (cnt_reg == 4'd0) state_next = STROBE;
      STROBE:  if (cnt_reg == 4'd0) state_next = HOLD;
      HOLD:    if (cnt_reg == 4'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Every pin is computed one cycle ahead so all bus outputs come straight from flops.
  always_comb begin
    cnt_next   = cnt_reg;
    we_next    = we_reg;
    wdata_next = wdata_reg;
    drive_next = drive_reg;
    cs_n_next  = cs_n_reg;
    rd_n_next  = rd_n_reg;
    wr_n_next  = wr_n_reg;
    a_next     = a_reg;
    rdata_next = rdata_reg;
    ack_next   = 1'b0;
    busy_next  = busy_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          we_next    = we;
          wdata_next = wdata;
          a_next     = addr;
          drive_next = we;
          cs_n_next  = 1'b0;
          busy_next  = 1'b1;
          cnt_next   = SETUP_LOAD;
        end
      end
      SETUP: begin
        if (cnt_reg == 4'd0) begin
          rd_n_next = we_reg;
          wr_n_next = !we_reg;
          cnt_next  = STROBE_LOAD;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_reg == 4'd0) begin
          rd_n_next = 1'b1;
          wr_n_next = 1'b1;
          cnt_next  = HOLD_LOAD;
          // Sampled on the edge that raises rd_n, so the PPI is still driving.
          if (!we_reg) rdata_next = bus_cpu;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_reg == 4'd0) begin
          cs_n_next  = 1'b1;
          drive_next = 1'b0;
          busy_next  = 1'b0;
          ack_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: ;
    endcase
  end

  assign bus_cpu = drive_reg ? wdata_reg : 8'hzz;
  assign rdata   = rdata_reg;
  assign ack     = ack_reg;
  assign busy    = busy_reg;
  assign cs_n    = cs_n_reg;
  assign rd_n    = rd_n_reg;
  assign wr_n    = wr_n_reg;
  assign a       = a_reg;

endmodule
